// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: op-word constants,
// clear-FSM state encoding and the byte-enable to bit-mask helper.
package regfile_pkg;

  localparam logic [3:0] OP_ALU_NIB = 4'h0;
  localparam logic [7:0] OP_WRITE   = 8'h11;
  localparam logic [7:0] OP_READ    = 8'h12;
  localparam logic [7:0] OP_CLEAR   = 8'h13;

  // Widest register the mask helper supports; callers truncate to DATA_WIDTH.
  localparam int MAX_BE = 8;
  localparam int MAX_W  = 8 * MAX_BE;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] be_to_mask(input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] mask;
    for (int b = 0; b < MAX_BE; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read lane: address mux, same-cycle write bypass merge,
// register-0 forcing and the rd_data/rd_valid output flops.
module regfile_read_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic [DATA_WIDTH-1:0] rd_next;

  // NOTE: combinational blocks assign a default first so no path leaves a latch.
  always_comb begin
    rd_next = mem[addr];
    if (BYPASS != 0 && wr_en && wr_addr == addr) begin
      rd_next = (mem[addr] & ~wr_mask) | (wr_data & wr_mask);
    end
    if (ZERO_REG != 0 && addr == '0) begin
      rd_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= en;
      rd_data  <= en ? rd_next : '0;
    end
  end

endmodule

// File: rtl/multi_port_register_file.sv
// Register file with N_READ registered read lanes, one byte-enabled write port,
// optional write-to-read bypass and a one-entry-per-cycle CLEAR sweep.
module multi_port_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int N_READ     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  op,
  input  logic [N_READ*ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  output logic [N_READ*DATA_WIDTH-1:0] rd_data,
  output logic [N_READ-1:0]            rd_valid,
  output logic                         busy,
  output logic                         wr_drop
);

  localparam int N_REG = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [N_REG];
  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  is_alu, is_write, is_read, is_clear;
  logic                  wr_req, wr_commit;
  logic [N_READ-1:0]     lane_en;
  logic                  unused_op;

  assign is_alu   = (op[15:12] == OP_ALU_NIB);
  assign is_write = (op[15:8]  == OP_WRITE);
  assign is_read  = (op[15:8]  == OP_READ);
  assign is_clear = (op[15:8]  == OP_CLEAR);
  assign unused_op = ^op[7:0];

  assign wr_mask   = DATA_WIDTH'(be_to_mask(MAX_BE'(wr_be)));
  assign wr_req    = (is_alu || is_write) && (wr_be != '0);
  // Writes to r0 with ZERO_REG set vanish without raising wr_drop.
  assign wr_commit = wr_req && (state == IDLE) && !(ZERO_REG != 0 && wr_addr == '0);
  assign busy      = (state == CLEAR);

  always_comb begin
    lane_en = '0;
    if (state == IDLE) begin
      if (is_alu)       lane_en    = '1;
      else if (is_read) lane_en[0] = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (is_clear) next_state = CLEAR;
      CLEAR:   if (clr_ptr == ADDR_WIDTH'(N_REG - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clr_ptr <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= next_state;
      clr_ptr <= (state == CLEAR) ? clr_ptr + ADDR_WIDTH'(1) : '0;
      wr_drop <= wr_req && (state == CLEAR);
    end
  end

  // NOTE: the storage array is reset because reset must leave every entry reading 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REG; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_lane
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .en       (lane_en[k]),
      .addr     (rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem      (mem),
      .wr_en    (wr_commit),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_mask  (wr_mask),
      .rd_data  (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid (rd_valid[k])
    );
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Bench for multi_port_register_file: two instances (bypass / zero-reg variants)
// checked every cycle against an array-based reference model.
module tb_multi_port_register_file;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NR   = 2;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     op;
  logic [NR*AW-1:0] rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_be;

  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_valid_a, rd_valid_b;
  logic             busy_a, busy_b, wr_drop_a, wr_drop_b;

  multi_port_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR),
                             .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .op(op), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .busy(busy_a), .wr_drop(wr_drop_a));

  multi_port_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR),
                             .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .op(op), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .busy(busy_b), .wr_drop(wr_drop_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: config 0 = bypass on, zero-reg off; config 1 = bypass off, zero-reg on.
  logic [15:0] ref_mem [2][NREG];
  int          clr_left = 0;
  int          busy_seen = 0;
  bit          cfg_bypass [2] = '{1'b1, 1'b0};
  bit          cfg_zero   [2] = '{1'b0, 1'b1};

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic step(input logic [15:0] o, input logic [7:0] ra, input logic [3:0] wa,
                      input logic [15:0] wd, input logic [1:0] be, input bit rst);
    logic [31:0] exp_data [2];
    logic [1:0]  exp_valid;
    logic        exp_drop, exp_busy;
    bit          alu_op, wr_op, rd_op, clr_op, busy_now, wr_req, commit;
    logic [3:0]  la;
    logic [15:0] val;
    op = o; rd_addr = ra; wr_addr = wa; wr_data = wd; wr_be = be; reset = rst;
    exp_data[0] = '0; exp_data[1] = '0; exp_valid = '0; exp_drop = 1'b0;
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < NREG; a++) ref_mem[c][a] = '0;
      clr_left = 0;
    end else begin
      alu_op   = (o[15:12] == 4'h0);
      wr_op    = (o[15:8] == 8'h11);
      rd_op    = (o[15:8] == 8'h12);
      clr_op   = (o[15:8] == 8'h13);
      busy_now = (clr_left > 0);
      wr_req   = (alu_op || wr_op) && (be != 2'b00);
      exp_drop = wr_req && busy_now;
      for (int k = 0; k < NR; k++)
        exp_valid[k] = !busy_now && (alu_op || (rd_op && k == 0));
      for (int c = 0; c < 2; c++) begin
        commit = wr_req && !busy_now && !(cfg_zero[c] && wa == 4'd0);
        for (int k = 0; k < NR; k++) begin
          if (exp_valid[k]) begin
            la  = ra[k*4 +: 4];
            val = ref_mem[c][la];
            if (cfg_bypass[c] && commit && la == wa) val = merge(val, wd, be);
            if (cfg_zero[c] && la == 4'd0) val = '0;
            exp_data[c][k*16 +: 16] = val;
          end
        end
        if (busy_now) ref_mem[c][4'(NREG - clr_left)] = '0;
        else if (commit) ref_mem[c][wa] = merge(ref_mem[c][wa], wd, be);
      end
      if (busy_now) clr_left--;
      else if (clr_op) clr_left = NREG;
    end
    exp_busy = (clr_left > 0);
    @(posedge clk);
    #1;
    check("rd_data_a", rd_data_a, exp_data[0]);
    check("rd_data_b", rd_data_b, exp_data[1]);
    check("rd_valid_a", 32'(rd_valid_a), 32'(exp_valid));
    check("rd_valid_b", 32'(rd_valid_b), 32'(exp_valid));
    check("busy_a", 32'(busy_a), 32'(exp_busy));
    check("busy_b", 32'(busy_b), 32'(exp_busy));
    check("wr_drop_a", 32'(wr_drop_a), 32'(exp_drop));
    check("wr_drop_b", 32'(wr_drop_b), 32'(exp_drop));
    if (busy_a) busy_seen++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    step(16'h1100, 8'h00, a, d, be, 1'b0);
  endtask
  task automatic rd(input logic [3:0] a);
    step(16'h1200, {4'h0, a}, 4'h0, 16'h0, 2'b00, 1'b0);
  endtask
  task automatic alu(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [1:0] be);
    step(16'h0000, {a1, a0}, wa, wd, be, 1'b0);
  endtask
  task automatic nop();
    step(16'hF000, 8'h00, 4'h0, 16'h0, 2'b00, 1'b0);
  endtask
  task automatic clr();
    step(16'h1300, 8'h00, 4'h0, 16'h0, 2'b00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] o;
    int          r;

    step(16'hF000, 8'h00, 4'h0, 16'h0, 2'b00, 1'b1);
    check("reset busy", 32'(busy_a), 32'd0);

    // Basic write then dual-lane read.
    wr(4'd5, 16'h1234, 2'b11);
    alu(4'd5, 4'd5, 4'd0, 16'h0, 2'b00);
    check("t1 lane0", 32'(rd_data_a[15:0]), 32'h1234);
    check("t1 lane1", 32'(rd_data_a[31:16]), 32'h1234);
    check("t1 valid", 32'(rd_valid_a), 32'h3);

    // Same-cycle partial write and read of r3.
    wr(4'd3, 16'hAAAA, 2'b11);
    alu(4'd3, 4'd5, 4'd3, 16'h5555, 2'b01);
    check("t2 bypass on", 32'(rd_data_a[15:0]), 32'hAA55);
    check("t2 bypass off", 32'(rd_data_b[15:0]), 32'hAAAA);
    rd(4'd3);
    check("t2 next a", 32'(rd_data_a[15:0]), 32'hAA55);
    check("t2 next b", 32'(rd_data_b[15:0]), 32'hAA55);

    // Fill, then full clear sweep.
    for (int i = 0; i < NREG; i++) wr(4'(i), 16'(16'h0101 * i), 2'b11);
    rd(4'd10);
    check("t3 fill r10", 32'(rd_data_a[15:0]), 32'h0A0A);
    busy_seen = 0;
    clr();
    for (int i = 0; i < 24; i++) nop();
    check("t3 busy cycles", 32'(busy_seen), 32'd16);
    for (int i = 0; i < NREG; i++) alu(4'(i), 4'(15 - i), 4'd0, 16'h0, 2'b00);
    check("t3 r15 cleared", 32'(rd_data_a), 32'h0);

    // Write during sweep is dropped; re-issued CLEAR does not extend the sweep.
    wr(4'd7, 16'h7777, 2'b11);
    busy_seen = 0;
    clr();
    wr(4'd7, 16'hBEEF, 2'b11);
    check("t4 wr_drop", 32'(wr_drop_a), 32'd1);
    for (int i = 0; i < 4; i++) nop();
    clr();
    for (int i = 0; i < 20; i++) nop();
    check("t4 busy cycles", 32'(busy_seen), 32'd16);
    rd(4'd7);
    check("t4 r7", 32'(rd_data_a[15:0]), 32'h0);

    // Zero-register instance: r0 writes vanish silently.
    wr(4'd0, 16'hFFFF, 2'b11);
    check("t5 no drop", 32'(wr_drop_b), 32'd0);
    rd(4'd0);
    check("t5 r0 data", 32'(rd_data_b[15:0]), 32'h0);
    check("t5 r0 valid", 32'(rd_valid_b[0]), 32'd1);

    // Reset in the fifth busy cycle aborts the sweep and clears everything.
    wr(4'd9, 16'h0077, 2'b11);
    wr(4'd2, 16'h0022, 2'b11);
    clr();
    for (int i = 0; i < 4; i++) nop();
    step(16'hF000, 8'h00, 4'h0, 16'h0, 2'b00, 1'b1);
    check("t6 busy", 32'(busy_a), 32'd0);
    check("t6 valid", 32'(rd_valid_a), 32'd0);
    alu(4'd9, 4'd2, 4'd0, 16'h0, 2'b00);
    check("t6 r9 r2", 32'(rd_data_a), 32'h0);
    wr(4'd9, 16'h00C3, 2'b11);
    rd(4'd9);
    check("t6 r9 after", 32'(rd_data_a[15:0]), 32'h00C3);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      o = 16'($urandom);
      if (r < 35)      o[15:12] = 4'h0;
      else if (r < 60) o[15:8]  = 8'h11;
      else if (r < 80) o[15:8]  = 8'h12;
      else if (r < 83) o[15:8]  = 8'h13;
      else             o[15:12] = 4'($urandom_range(2, 15));
      step(o, 8'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
           $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
